// File: rtl/rank_cmd_arbiter.sv
// Round-robin arbiter that feeds per-rank command queues onto one CMD bus.
// A rank change costs a SWITCH/WAIT detour that waits for the tRTRS turnaround.
module rank_cmd_arbiter #(
  parameter int NUM_RANK = 4,
  parameter int CMD_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RANK-1:0]         cmdReq,
  input  logic [NUM_RANK*CMD_W-1:0]   cmdPayload,
  input  logic                        CMDTurnaroundFree,
  output logic [NUM_RANK-1:0]         cmdGrant,
  output logic                        cmdValid,
  output logic [CMD_W-1:0]            cmdOut,
  output logic [$clog2(NUM_RANK)-1:0] cmdRank,
  output logic                        rankTransition
);

  localparam int RW = $clog2(NUM_RANK);

  typedef enum logic [1:0] {IDLE, SWITCH, WAIT} state_t;

  state_t        stateReg, stateNext;
  logic [RW-1:0] rrPtrReg, rrPtrNext;
  logic [RW-1:0] lastRankReg, lastRankNext;
  logic          lastValidReg, lastValidNext;
  logic [RW-1:0] targetRankReg, targetRankNext;

  logic [RW-1:0]       rotIdx [NUM_RANK];
  logic [NUM_RANK-1:0] rotReq;
  logic                winValid;
  logic [RW-1:0]       winRank;
  logic                grantValid;
  logic [RW-1:0]       grantRank;

  // Requests rotated so that position 0 is the rank at rrPtr.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RANK; gi++) begin : g_rot
      assign rotIdx[gi] = rrPtrReg + RW'(gi);
      assign rotReq[gi] = cmdReq[rotIdx[gi]];
    end
  endgenerate

  // Descending scan so the lowest rotated position is the last one kept.
  always_comb begin
    winValid = 1'b0;
    winRank  = '0;
    for (int i = NUM_RANK - 1; i >= 0; i--) begin
      if (rotReq[i]) begin
        winValid = 1'b1;
        winRank  = rotIdx[i];
      end
    end
  end

  always_comb begin
    stateNext      = stateReg;
    rrPtrNext      = rrPtrReg;
    lastRankNext   = lastRankReg;
    lastValidNext  = lastValidReg;
    targetRankNext = targetRankReg;
    grantValid     = 1'b0;
    grantRank      = winRank;

    case (stateReg)
      IDLE: begin
        if (winValid) begin
          if (!lastValidReg || (winRank == lastRankReg)) begin
            grantValid = CMDTurnaroundFree;
          end else begin
            targetRankNext = winRank;
            stateNext      = SWITCH;
          end
        end
      end
      SWITCH: stateNext = WAIT;
      WAIT: begin
        grantRank = targetRankReg;
        if (CMDTurnaroundFree) begin
          stateNext = IDLE;
          if (cmdReq[targetRankReg]) begin
            grantValid = 1'b1;
          end else begin
            // Bus already belongs to the target rank, so later requests from it
            // need no further turnaround.
            lastRankNext  = targetRankReg;
            lastValidNext = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if (!rst) begin
      grantValid = 1'b0;
    end

    if (grantValid) begin
      lastRankNext  = grantRank;
      lastValidNext = 1'b1;
      rrPtrNext     = grantRank + RW'(1);
    end
  end

  generate
    for (gi = 0; gi < NUM_RANK; gi++) begin : g_grant
      assign cmdGrant[gi] = grantValid && (grantRank == RW'(gi));
    end
  endgenerate

  assign rankTransition = (stateReg == SWITCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg      <= IDLE;
      rrPtrReg      <= '0;
      lastRankReg   <= '0;
      lastValidReg  <= 1'b0;
      targetRankReg <= '0;
      cmdValid      <= 1'b0;
      cmdOut        <= '0;
      cmdRank       <= '0;
    end else begin
      stateReg      <= stateNext;
      rrPtrReg      <= rrPtrNext;
      lastRankReg   <= lastRankNext;
      lastValidReg  <= lastValidNext;
      targetRankReg <= targetRankNext;
      cmdValid      <= grantValid;
      if (grantValid) begin
        cmdOut  <= cmdPayload[grantRank*CMD_W +: CMD_W];
        cmdRank <= grantRank;
      end
    end
  end

endmodule

// File: tb/tb_rank_cmd_arbiter.sv
// Scoreboard bench for rank_cmd_arbiter with a tRTRS=2 turnaround model in loop.
module tb_rank_cmd_arbiter;

  localparam int NR = 4;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   cmdReq = '0;
  logic [NR*CW-1:0] cmdPayload = '0;
  logic            CMDTurnaroundFree;
  logic [NR-1:0]   cmdGrant;
  logic            cmdValid;
  logic [CW-1:0]   cmdOut;
  logic [1:0]      cmdRank;
  logic            rankTransition;

  logic            forceLow = 1'b0;
  logic [1:0]      tCnt;
  int              cyc = 0;
  int              seq = 0;
  logic            done = 1'b0;
  int              checks = 0;
  int              failures = 0;

  typedef struct { int cyc; logic [NR-1:0] grant; logic rt; } cycExp_t;
  typedef struct { int cyc; logic [1:0] rank; logic [CW-1:0] pay; } outExp_t;
  cycExp_t cycQ[$];
  outExp_t outQ[$];
  cycExp_t ce;
  outExp_t oe;

  rank_cmd_arbiter #(.NUM_RANK(NR), .CMD_W(CW)) dut (
    .clk(clk), .rst(rst), .cmdReq(cmdReq), .cmdPayload(cmdPayload),
    .CMDTurnaroundFree(CMDTurnaroundFree), .cmdGrant(cmdGrant),
    .cmdValid(cmdValid), .cmdOut(cmdOut), .cmdRank(cmdRank),
    .rankTransition(rankTransition)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Turnaround model: busy during the SWITCH cycle and the one after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tCnt <= '0;
    else if (rankTransition) tCnt <= 2'd1;
    else if (tCnt != 0) tCnt <= tCnt - 2'd1;
  end
  assign CMDTurnaroundFree = (tCnt == 0) && !rankTransition && !forceLow;

  task automatic cyc1(input logic [NR-1:0] req, input logic low,
                      input logic [NR-1:0] expGrant, input logic expRt);
    @(posedge clk); #1;
    seq++;
    cmdReq   = req;
    forceLow = low;
    for (int r = 0; r < NR; r++)
      cmdPayload[r*CW +: CW] = 32'hA500_0000 | 32'(seq << 8) | 32'(r);
    cycQ.push_back('{cyc, expGrant, expRt});
    for (int r = 0; r < NR; r++)
      if (expGrant[r]) outQ.push_back('{cyc + 1, 2'(r), cmdPayload[r*CW +: CW]});
  endtask

  task automatic doReset(input logic clearReq);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (clearReq) cmdReq = '0;
    rst = 1'b1;
  endtask

  // Monitor: all comparisons happen here, decoupled from the stimulus.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (cmdValid !== 1'b0 || cmdOut !== '0 || cmdRank !== '0 ||
          rankTransition !== 1'b0 || cmdGrant !== '0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d: valid=%b out=%h rank=%0d rt=%b grant=%b, required all zero",
                 cyc, cmdValid, cmdOut, cmdRank, rankTransition, cmdGrant);
      end
    end else begin
      if (cycQ.size() > 0 && cycQ[0].cyc == cyc) begin
        ce = cycQ.pop_front();
        checks++;
        if (cmdGrant !== ce.grant || rankTransition !== ce.rt) begin
          failures++;
          $display("FAIL grant_rt cyc=%0d: grant=%b rt=%b, required grant=%b rt=%b",
                   cyc, cmdGrant, rankTransition, ce.grant, ce.rt);
        end
      end
      if (cmdValid === 1'b1) begin
        checks++;
        if (outQ.size() == 0) begin
          failures++;
          $display("FAIL cmd_unexpected cyc=%0d: valid=1 rank=%0d out=%h, required valid=0",
                   cyc, cmdRank, cmdOut);
        end else begin
          oe = outQ.pop_front();
          if (oe.cyc != cyc || cmdRank !== oe.rank || cmdOut !== oe.pay) begin
            failures++;
            $display("FAIL cmd_out cyc=%0d: rank=%0d out=%h, required cyc=%0d rank=%0d out=%h",
                     cyc, cmdRank, cmdOut, oe.cyc, oe.rank, oe.pay);
          end
        end
      end else if (outQ.size() > 0 && outQ[0].cyc <= cyc) begin
        checks++;
        failures++;
        oe = outQ.pop_front();
        $display("FAIL cmd_missing cyc=%0d: valid=%b, required valid=1 rank=%0d out=%h",
                 cyc, cmdValid, oe.rank, oe.pay);
      end
    end
    if (done || cyc > 5000) begin
      checks++;
      if (!done || cycQ.size() != 0 || outQ.size() != 0) begin
        failures++;
        $display("FAIL drain cyc=%0d: done=%b pending_cyc=%0d pending_out=%0d, required done=1 and 0 pending",
                 cyc, done, cycQ.size(), outQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // V1: single request after reset, issued with no transition
    cyc1(4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc1(4'b0000, 1'b0, 4'b0000, 1'b0);

    // V2: rank 1 streams four commands back to back
    doReset(1'b1);
    for (int k = 0; k < 4; k++) cyc1(4'b0010, 1'b0, 4'b0010, 1'b0);
    cyc1(4'b0000, 1'b0, 4'b0000, 1'b0);

    // V3: rank 0 then rank 3 through the turnaround model
    doReset(1'b1);
    cyc1(4'b0001, 1'b0, 4'b0001, 1'b0);
    cyc1(4'b1000, 1'b0, 4'b0000, 1'b0);
    cyc1(4'b1000, 1'b0, 4'b0000, 1'b1);
    cyc1(4'b1000, 1'b0, 4'b0000, 1'b0);
    cyc1(4'b1000, 1'b0, 4'b1000, 1'b0);
    cyc1(4'b0000, 1'b0, 4'b0000, 1'b0);

    // V4: all ranks requesting, rotation 1,2,3,0 with a switch before each
    doReset(1'b1);
    cyc1(4'b0001, 1'b0, 4'b0001, 1'b0);
    for (int t = 1; t <= 4; t++) begin
      cyc1(4'b1111, 1'b0, 4'b0000, 1'b0);
      cyc1(4'b1111, 1'b0, 4'b0000, 1'b1);
      cyc1(4'b1111, 1'b0, 4'b0000, 1'b0);
      cyc1(4'b1111, 1'b0, 4'(1 << (t % 4)), 1'b0);
    end
    cyc1(4'b0000, 1'b0, 4'b0000, 1'b0);

    // V5: target drops its request while WAIT is blocked
    doReset(1'b1);
    cyc1(4'b0001, 1'b0, 4'b0001, 1'b0);
    cyc1(4'b0100, 1'b1, 4'b0000, 1'b0);
    cyc1(4'b0100, 1'b1, 4'b0000, 1'b1);
    cyc1(4'b0100, 1'b1, 4'b0000, 1'b0);
    cyc1(4'b0000, 1'b1, 4'b0000, 1'b0);
    cyc1(4'b0000, 1'b0, 4'b0000, 1'b0);
    cyc1(4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc1(4'b0000, 1'b0, 4'b0000, 1'b0);

    // V6: reset while WAIT holds a pending switch
    doReset(1'b1);
    cyc1(4'b1000, 1'b0, 4'b1000, 1'b0);
    cyc1(4'b0010, 1'b0, 4'b0000, 1'b0);
    cyc1(4'b0010, 1'b0, 4'b0000, 1'b1);
    cyc1(4'b0010, 1'b1, 4'b0000, 1'b0);
    doReset(1'b1);
    cyc1(4'b0010, 1'b0, 4'b0010, 1'b0);
    cyc1(4'b0000, 1'b0, 4'b0000, 1'b0);

    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule

// File: doc/rank_cmd_arbiter.md
RANK_CMD_ARBITER -- requirements
Module: RankCMDArbiter

Interface
REQ-001 Parameter NUM_RANK, default 4: number of per-rank command queues arbitrated, power of two, at least 2.
REQ-002 Parameter CMD_W, default 32: width of one command payload in bits.
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port cmdReq, input, NUM_RANK: per-rank request; bit r high means queue r holds a pending command.
REQ-006 Port cmdPayload, input, NUM_RANK*CMD_W: per-rank command; slice r is bits [r*CMD_W +: CMD_W].
REQ-007 Port CMDTurnaroundFree, input, 1: high means the tRTRS rank-to-rank turnaround is not in progress.
REQ-008 Port cmdGrant, output, NUM_RANK: one-hot combinational accept strobe; queue r dequeues when bit r is high.
REQ-009 Port cmdValid, output, 1: a registered command is on the CMD bus this cycle.
REQ-010 Port cmdOut, output, CMD_W: the registered command payload.
REQ-011 Port cmdRank, output, $clog2(NUM_RANK): the registered rank index of cmdOut.
REQ-012 Port rankTransition, output, 1: one-cycle pulse requesting a CMD-bus rank switch; it drives the turnaround block's rankTransition input.

Function
REQ-013 The FSM SHALL have three states: IDLE, SWITCH and WAIT.
REQ-014 Winner: the first requesting rank searched upward from rrPtr, wrapping modulo NUM_RANK.
REQ-015 IDLE, issue condition: a winner exists, and either lastValid==0 or winner==lastRank, and CMDTurnaroundFree==1.
REQ-016 When the issue condition holds, cmdGrant[winner] SHALL be 1 in the same cycle, and the next edge SHALL set:
  - cmdValid=1, cmdOut=payload[winner], cmdRank=winner;
  - lastRank=winner, lastValid=1;
  - rrPtr=(winner+1) mod NUM_RANK.
REQ-017 IDLE, switch condition: a winner exists, lastValid==1 and winner!=lastRank. Then cmdGrant SHALL be 0, targetRank<=winner, and the next state SHALL be SWITCH, independent of CMDTurnaroundFree.
REQ-018 SWITCH SHALL last exactly one cycle with rankTransition=1 and cmdGrant=0, then go to WAIT.
REQ-019 rankTransition SHALL equal (state==SWITCH) and SHALL NOT depend combinationally on any input; this prevents a loop through CMDTurnaroundFree.
REQ-020 WAIT with CMDTurnaroundFree==0: hold in WAIT, no grant, no rankTransition.
REQ-021 WAIT with CMDTurnaroundFree==1 and cmdReq[targetRank]==1: issue targetRank exactly as in REQ-016, then go to IDLE.
REQ-022 WAIT with CMDTurnaroundFree==1 and cmdReq[targetRank]==0:
  - no issue;
  - lastRank<=targetRank, lastValid<=1, rrPtr unchanged;
  - go to IDLE.
REQ-023 cmdValid SHALL be 1 only in the cycle after a grant and 0 otherwise; cmdOut and cmdRank SHALL hold their value when cmdValid==0.
REQ-024 cmdGrant SHALL be all-zero or one-hot, and SHALL only be high on a bit whose cmdReq is high.
REQ-025 The same rank SHALL be issuable on consecutive cycles, giving one command per cycle while it holds the winner position.
REQ-026 Latency:
  - same-rank request to cmdValid is 1 cycle;
  - a rank switch with free turnaround is 4 cycles (decision D, SWITCH D+1, WAIT D+2, grant D+3, cmdValid D+4) when tRTRS=2.
REQ-027 rrPtr wrap: after a grant to rank NUM_RANK-1, rrPtr SHALL be 0.

Reset
REQ-028 While rst==0, the block SHALL hold:
  - state=IDLE, rrPtr=0, lastRank=0, lastValid=0, targetRank=0;
  - cmdValid=0, cmdOut=0, cmdRank=0;
  - rankTransition=0, cmdGrant=0.
REQ-029 A reset asserted in SWITCH or WAIT SHALL abandon the pending switch; after release, the first grant SHALL need no transition.

Verification
REQ-030 The bench SHALL cover these directed scenarios, each as stimulus -> required response:
  - V1: after reset, cmdReq=0b0100, Free=1 -> cmdGrant=0b0100 in the same cycle; next cycle cmdValid=1, cmdRank=2; rankTransition never 1.
  - V2: rank 1 held requesting for 4 cycles, Free=1 -> four grants on consecutive cycles; cmdValid high for 4 consecutive cycles; payloads in order.
  - V3: lastRank=0, then only rank 3 requests, with a real tRTRS=2 turnaround block in loop -> rankTransition pulses exactly once at D+1; grant at D+3; cmdValid with cmdRank=3 at D+4.
  - V4: cmdReq=0b1111 held, lastRank=0, rrPtr=1 -> switch to rank 1; then ranks 1,2,3,0 in rotation, each preceded by one rankTransition pulse.
  - V5: in WAIT, drop cmdReq[target] before Free rises -> no grant; FSM returns to IDLE with lastRank=target; a later request from target issues without rankTransition.
  - V6: assert rst during WAIT -> outputs zero immediately; after release, a request from any rank issues with no rankTransition.
